// File: rtl/seg_display_decoder.sv
// Decodes four active-low 7-segment digit buses back into BCD digits and a binary count,
// with glitch filtering, illegal-pattern detection and a +1-per-reading continuity check.
module seg_display_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic [6:0]           HEX0,
  input  logic [6:0]           HEX1,
  input  logic [6:0]           HEX2,
  input  logic [6:0]           HEX3,
  output logic [15:0]          DIGITS,
  output logic [13:0]          VALUE,
  output logic                 VALID,
  output logic                 BLANK,
  output logic                 ERR,
  output logic                 SKIP,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [7:0]  STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [3:0]  DASH_CODE = 4'd10;
  localparam logic [27:0] ALL_OFF   = {4{7'h7F}};

  // Returns {legal, code}; segment bits are ordered g..a.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode_seg = {1'b1, 4'd0};
      7'b1111001: decode_seg = {1'b1, 4'd1};
      7'b0100100: decode_seg = {1'b1, 4'd2};
      7'b0110000: decode_seg = {1'b1, 4'd3};
      7'b0011001: decode_seg = {1'b1, 4'd4};
      7'b0010010: decode_seg = {1'b1, 4'd5};
      7'b0000010: decode_seg = {1'b1, 4'd6};
      7'b1111000: decode_seg = {1'b1, 4'd7};
      7'b0000000: decode_seg = {1'b1, 4'd8};
      7'b0010000: decode_seg = {1'b1, 4'd9};
      7'b0111111: decode_seg = {1'b1, DASH_CODE};
      default:    decode_seg = {1'b0, 4'd0};
    endcase
  endfunction

  // Constant multiplies expanded to shift/add: 1000 = 512+256+128+64+32+8, 100 = 64+32+4, 10 = 8+2.
  function automatic logic [13:0] to_binary(input logic [15:0] d);
    logic [13:0] d3, d2, d1, d0;
    d3 = {10'd0, d[15:12]};
    d2 = {10'd0, d[11:8]};
    d1 = {10'd0, d[7:4]};
    d0 = {10'd0, d[3:0]};
    to_binary = (d3 << 9) + (d3 << 8) + (d3 << 7) + (d3 << 6) + (d3 << 5) + (d3 << 3)
              + (d2 << 6) + (d2 << 5) + (d2 << 2)
              + (d1 << 3) + (d1 << 1)
              + d0;
  endfunction

  logic [27:0] hex_in;
  logic [27:0] s_reg;
  logic [27:0] committed_reg;
  logic [7:0]  stab_cnt_reg;
  logic        have_prev_reg;

  logic [4:0]  dec [4];
  logic [3:0]  legal;
  logic [3:0]  dash;
  logic [15:0] digits_next;

  assign hex_in = {HEX3, HEX2, HEX1, HEX0};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign dec[gi]                 = decode_seg(s_reg[gi*7 +: 7]);
      assign legal[gi]               = dec[gi][4];
      assign dash[gi]                = dec[gi][4] && (dec[gi][3:0] == DASH_CODE);
      assign digits_next[gi*4 +: 4]  = dec[gi][3:0];
    end
  endgenerate

  logic        same;
  logic        commit;
  logic        all_legal;
  logic        any_dash;
  logic [13:0] value_next;
  logic [13:0] value_inc;

  assign same       = (hex_in == s_reg);
  // The counter crossing into STAB_MAX happens exactly once per stable run, so commit cannot repeat.
  assign commit     = same && (stab_cnt_reg == STAB_MAX - 8'd1) && (s_reg != committed_reg);
  assign all_legal  = &legal;
  assign any_dash   = |dash;
  assign value_next = to_binary(digits_next);
  assign value_inc  = (VALUE == 14'd9999) ? 14'd0 : VALUE + 14'd1;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      s_reg         <= ALL_OFF;
      committed_reg <= ALL_OFF;
      stab_cnt_reg  <= 8'd0;
      have_prev_reg <= 1'b0;
      DIGITS        <= 16'd0;
      VALUE         <= 14'd0;
      VALID         <= 1'b0;
      BLANK         <= 1'b0;
      ERR           <= 1'b0;
      SKIP          <= 1'b0;
      ERR_CNT       <= '0;
    end else begin
      s_reg <= hex_in;
      if (!same)
        stab_cnt_reg <= 8'd0;
      else if (stab_cnt_reg != STAB_MAX)
        stab_cnt_reg <= stab_cnt_reg + 8'd1;

      VALID <= 1'b0;
      ERR   <= 1'b0;
      SKIP  <= 1'b0;

      if (commit) begin
        committed_reg <= s_reg;
        if (all_legal) begin
          DIGITS <= digits_next;
          VALID  <= 1'b1;
          if (any_dash) begin
            BLANK         <= 1'b1;
            have_prev_reg <= 1'b0;
          end else begin
            BLANK         <= 1'b0;
            VALUE         <= value_next;
            // A reading of zero is a stopwatch clear, never a discontinuity.
            SKIP          <= have_prev_reg && (value_next != value_inc) && (value_next != 14'd0);
            have_prev_reg <= 1'b1;
          end
        end else begin
          ERR <= 1'b1;
          if (ERR_CNT != {ERR_CNT_W{1'b1}})
            ERR_CNT <= ERR_CNT + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder: hand-computed expectations, pulse counting monitor.
module tb_seg_display_decoder;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [15:0] DIGITS;
  logic [13:0] VALUE;
  logic        VALID, BLANK, ERR, SKIP;
  logic [7:0]  ERR_CNT;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int ecnt  = 0;
  int scnt  = 0;
  int v0, e0, s0;

  seg_display_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .HEX0(HEX0),
    .HEX1(HEX1),
    .HEX2(HEX2),
    .HEX3(HEX3),
    .DIGITS(DIGITS),
    .VALUE(VALUE),
    .VALID(VALID),
    .BLANK(BLANK),
    .ERR(ERR),
    .SKIP(SKIP),
    .ERR_CNT(ERR_CNT)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Pulses are counted on the falling edge, half a cycle after they are registered.
  always @(negedge CLOCK_50) begin
    if (!RESET) begin
      if (VALID) vcnt++;
      if (ERR)   ecnt++;
      if (SKIP)  scnt++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  endfunction

  task automatic mark();
    v0 = vcnt;
    e0 = ecnt;
    s0 = scnt;
  endtask

  task automatic apply_raw(input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h1, input logic [6:0] h0, input int n);
    @(negedge CLOCK_50);
    HEX3 = h3; HEX2 = h2; HEX1 = h1; HEX0 = h0;
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic apply(input int d3, input int d2, input int d1, input int d0, input int n);
    apply_raw(seg(d3), seg(d2), seg(d1), seg(d0), n);
  endtask

  task automatic step(input string tag, input int d3, input int d2, input int d1, input int d0,
                      input int exp_v, input int exp_s, input int exp_value);
    mark();
    apply(d3, d2, d1, d0, 10);
    chk({tag, "_valid"}, vcnt - v0, exp_v);
    chk({tag, "_skip"},  scnt - s0, exp_s);
    chk({tag, "_value"}, int'(VALUE), exp_value);
  endtask

  initial begin
    RESET = 1'b1;
    HEX3 = 7'h7F; HEX2 = 7'h7F; HEX1 = 7'h7F; HEX0 = 7'h7F;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_digits", int'(DIGITS), 0);
    chk("rst_value", int'(VALUE), 0);
    chk("rst_pulses", int'({VALID, BLANK, ERR, SKIP}), 0);
    chk("rst_errcnt", int'(ERR_CNT), 0);
    @(negedge CLOCK_50);
    RESET = 1'b0;

    // Latency: commit lands on the 5th edge after the change.
    mark();
    apply(0, 0, 0, 0, 4);
    chk("lat_no_valid_e4", int'(VALID), 0);
    @(posedge CLOCK_50); #1;
    chk("lat_valid_e5", int'(VALID), 1);
    chk("zero_digits", int'(DIGITS), 0);
    chk("zero_skip", int'(SKIP), 0);
    repeat (10) @(posedge CLOCK_50); #1;
    chk("zero_hold_pulses", vcnt - v0, 1);

    step("s0001", 0, 0, 0, 1, 1, 0, 1);
    step("s0002", 0, 0, 0, 2, 1, 0, 2);
    step("s9999", 9, 9, 9, 9, 1, 1, 9999);
    step("wrap0000", 0, 0, 0, 0, 1, 0, 0);
    step("s0005", 0, 0, 0, 5, 1, 1, 5);

    // Illegal HEX0 pattern: a single ERR, displayed state held.
    mark();
    apply_raw(seg(0), seg(0), seg(0), 7'h7F, 10);
    chk("ill_err", ecnt - e0, 1);
    chk("ill_valid", vcnt - v0, 0);
    chk("ill_errcnt", int'(ERR_CNT), 1);
    chk("ill_digits", int'(DIGITS), 16'h0005);
    chk("ill_value", int'(VALUE), 5);

    for (int i = 0; i < 300; i++)
      apply_raw(seg(0), seg(0), seg(0), (i % 2 == 0) ? 7'h7E : 7'h7F, 6);
    chk("errcnt_sat", int'(ERR_CNT), 255);

    // Fast toggling never settles long enough to commit.
    mark();
    for (int i = 0; i < 20; i++)
      apply(0, 0, 0, (i % 2 == 0) ? 3 : 8, 2);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_err", ecnt - e0, 0);

    mark();
    apply(10, 0, 0, 3, 10);
    chk("dash_valid", vcnt - v0, 1);
    chk("dash_blank", int'(BLANK), 1);
    chk("dash_d3", int'(DIGITS[15:12]), 10);
    chk("dash_value", int'(VALUE), 5);
    chk("dash_skip", scnt - s0, 0);

    // After a dash there is no previous reading, so no SKIP.
    step("s0006", 0, 0, 0, 6, 1, 0, 6);
    chk("s0006_blank", int'(BLANK), 0);

    // Asynchronous reset mid-filter, while stab_cnt is 3.
    apply(0, 0, 0, 7, 4);
    chk("pre_rst_value", int'(VALUE), 6);
    #1;
    RESET = 1'b1;
    #1;
    chk("arst_value", int'(VALUE), 0);
    chk("arst_digits", int'(DIGITS), 0);
    chk("arst_errcnt", int'(ERR_CNT), 0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    mark();
    repeat (4) @(posedge CLOCK_50); #1;
    chk("arst_no_valid_e4", int'(VALID), 0);
    @(posedge CLOCK_50); #1;
    chk("arst_valid_e5", int'(VALID), 1);
    chk("arst_skip", int'(SKIP), 0);
    chk("arst_value7", int'(VALUE), 7);
    repeat (5) @(posedge CLOCK_50); #1;
    chk("arst_pulses", vcnt - v0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
